branch_accuracy_monitor: RTL and testbench

- Sits directly downstream of the branch predictor top level. It consumes each resolved branch as a (prediction, actual outcome) pair and accumulates accuracy statistics.
- Tracks lifetime counts, mispredict streaks and a sliding-window hit count. Raises a hysteretic low-accuracy alarm.
- Software/bench controls it via start/stop/clear. All outputs are registered.

---
 rtl/branch_monitor_pkg.sv | 32 +++
 rtl/branch_accuracy_monitor_if.sv | 44 ++++
 rtl/sliding_window_counter.sv | 72 +++++++
 rtl/branch_accuracy_monitor.sv | 173 +++++++++++++++++
 tb/tb_branch_accuracy_monitor.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/branch_monitor_pkg.sv
// Shared types and helpers for the branch accuracy monitor.
//   mon_state_e    : monitor control state (idle / run / halt)
//   win_cnt_width  : width needed to count 0..win hits
//   sat_inc        : saturating increment for counters up to 32 bits wide
package branch_monitor_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } mon_state_e;

   localparam int unsigned DEFAULT_WIN = 16;

   function automatic int unsigned win_cnt_width(input int unsigned win);
      return $clog2(win + 1);
   endfunction

   // Width of the window hit counter for the default window depth.
   localparam int unsigned WIN_CNT_W = win_cnt_width(DEFAULT_WIN);

   // All-ones mask of the given width; a 32-bit shift wraps to 0, so 0 - 1 is still all ones.
   function automatic logic [31:0] ones_mask(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

   // Increment val, holding at all-ones of the given width.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      return (val == ones_mask(width)) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/branch_accuracy_monitor_if.sv
// Control, sample and statistics bundle of the branch accuracy monitor.
//   master : drives start/stop/clear and the resolved-branch sample, reads the statistics
//   slave  : the monitor itself
interface branch_accuracy_monitor_if
   import branch_monitor_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned WIN      = 16,
   parameter int unsigned STREAK_W = 8
);

   localparam int unsigned WinCntW = win_cnt_width(WIN);

   logic                start;
   logic                stop;
   logic                clear;
   logic                sample_valid;
   logic                prediction;
   logic                branch_outcome;

   logic [CNT_W-1:0]    total_count;
   logic [CNT_W-1:0]    correct_count;
   logic [CNT_W-1:0]    mispredict_count;
   logic [STREAK_W-1:0] cur_miss_streak;
   logic [STREAK_W-1:0] max_miss_streak;
   logic [WinCntW-1:0]  window_hits;
   logic                window_full;
   logic                low_acc_alarm;
   logic                sat_flag;
   logic                running;

   modport master (
      output start, stop, clear, sample_valid, prediction, branch_outcome,
      input  total_count, correct_count, mispredict_count, cur_miss_streak,
             max_miss_streak, window_hits, window_full, low_acc_alarm, sat_flag, running
   );

   modport slave (
      input  start, stop, clear, sample_valid, prediction, branch_outcome,
      output total_count, correct_count, mispredict_count, cur_miss_streak,
             max_miss_streak, window_hits, window_full, low_acc_alarm, sat_flag, running
   );

endinterface

// File: rtl/sliding_window_counter.sv
// Hit count over the last min(WIN, pushed) samples.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the window (beats push)
//   push       : shift bit_in into the window this cycle
//   hits/full  : registered hit count and window-full flag
//   hits_next/full_next : values those registers take on the next edge
// The count is maintained incrementally (in minus out), never by popcount.
module sliding_window_counter
   import branch_monitor_pkg::*;
#(
   parameter int unsigned WIN = 16,
   localparam int unsigned CntW = win_cnt_width(WIN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            push,
   input  logic            bit_in,
   output logic [CntW-1:0] hits,
   output logic [CntW-1:0] hits_next,
   output logic            full,
   output logic            full_next
);

   logic [WIN-1:0]  sr_q, sr_d;
   logic [CntW-1:0] fill_q, fill_d;
   logic [CntW-1:0] hits_q, hits_d;
   logic            full_q, full_d;

   always_comb begin
      sr_d   = sr_q;
      fill_d = fill_q;
      hits_d = hits_q;
      full_d = full_q;
      if (clear) begin
         sr_d   = '0;
         fill_d = '0;
         hits_d = '0;
         full_d = 1'b0;
      end else if (push) begin
         sr_d = {sr_q[WIN-2:0], bit_in};
         if (full_q) begin
            // Oldest sample leaves from the MSB as the new one enters.
            hits_d = hits_q + CntW'(bit_in) - CntW'(sr_q[WIN-1]);
         end else begin
            hits_d = hits_q + CntW'(bit_in);
            fill_d = fill_q + CntW'(1);
            full_d = (fill_d == CntW'(WIN));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q   <= '0;
         fill_q <= '0;
         hits_q <= '0;
         full_q <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         fill_q <= fill_d;
         hits_q <= hits_d;
         full_q <= full_d;
      end
   end

   assign hits      = hits_q;
   assign hits_next = hits_d;
   assign full      = full_q;
   assign full_next = full_d;

endmodule

// File: rtl/branch_accuracy_monitor.sv
// Branch prediction accuracy monitor.
// Consumes resolved (prediction, outcome) pairs while running and keeps lifetime counts,
// mispredict streaks, a sliding-window hit count and a hysteretic low-accuracy alarm.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of branch_accuracy_monitor_if (control, sample, statistics)
// All statistics outputs are registered and reflect an accepted sample one edge later.
// Counter widths up to 32 bits are supported by the saturating-increment helper.
module branch_accuracy_monitor
   import branch_monitor_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned WIN        = 16,
   parameter int unsigned STREAK_W   = 8,
   parameter int unsigned ALARM_LO   = 8,
   parameter int unsigned ALARM_HYST = 2
) (
   input logic                      clk,
   input logic                      reset,
   branch_accuracy_monitor_if.slave bus
);

   localparam int unsigned WinCntW = win_cnt_width(WIN);
   // One extra bit so ALARM_LO + ALARM_HYST may exceed the largest hit count.
   localparam int unsigned CmpW    = WinCntW + 1;
   localparam logic [CmpW-1:0] SetThr = CmpW'(ALARM_LO);
   localparam logic [CmpW-1:0] ClrThr = CmpW'(ALARM_LO + ALARM_HYST);

   mon_state_e          state_q, state_d;
   logic                running_q, running_d;
   logic                accept, hit;

   logic [CNT_W-1:0]    total_q, total_d;
   logic [CNT_W-1:0]    correct_q, correct_d;
   logic [CNT_W-1:0]    miss_q, miss_d;
   logic [STREAK_W-1:0] cur_q, cur_d, cur_inc;
   logic [STREAK_W-1:0] max_q, max_d;
   logic                alarm_q, alarm_d;
   logic                sat_q, sat_d;

   logic [WinCntW-1:0]  win_hits, win_hits_next;
   logic                win_full, win_full_next;
   logic [CmpW-1:0]     hits_cmp;

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
      end
   end

   // ---------------------------------------------------------------- FSM: next state
   // stop beats start; clear never changes the state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start && !bus.stop) state_d = StRun;
         StRun:   if (bus.stop) state_d = StHalt;
         StHalt:  if (bus.start && !bus.stop) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- FSM: outputs
   // Acceptance uses the current state, so a sample alongside stop still counts.
   always_comb begin
      accept    = bus.sample_valid && (state_q == StRun) && !bus.clear;
      running_d = (state_d == StRun);
   end

   assign hit = (bus.prediction == bus.branch_outcome);

   // ---------------------------------------------------------------- statistics
   assign cur_inc = STREAK_W'(sat_inc(32'(cur_q), STREAK_W));

   always_comb begin
      total_d   = total_q;
      correct_d = correct_q;
      miss_d    = miss_q;
      cur_d     = cur_q;
      max_d     = max_q;
      sat_d     = sat_q;
      if (bus.clear) begin
         total_d   = '0;
         correct_d = '0;
         miss_d    = '0;
         cur_d     = '0;
         max_d     = '0;
         sat_d     = 1'b0;
      end else if (accept) begin
         total_d = CNT_W'(sat_inc(32'(total_q), CNT_W));
         if (&total_q) sat_d = 1'b1;
         if (hit) begin
            correct_d = CNT_W'(sat_inc(32'(correct_q), CNT_W));
            if (&correct_q) sat_d = 1'b1;
            cur_d = '0;
         end else begin
            miss_d = CNT_W'(sat_inc(32'(miss_q), CNT_W));
            if (&miss_q) sat_d = 1'b1;
            cur_d = cur_inc;
            if (&cur_q) sat_d = 1'b1;
            max_d = (cur_inc > max_q) ? cur_inc : max_q;
         end
      end
   end

   // ---------------------------------------------------------------- sliding window
   sliding_window_counter #(
      .WIN (WIN)
   ) u_window (
      .clk       (clk),
      .reset     (reset),
      .clear     (bus.clear),
      .push      (accept),
      .bit_in    (hit),
      .hits      (win_hits),
      .hits_next (win_hits_next),
      .full      (win_full),
      .full_next (win_full_next)
   );

   // ---------------------------------------------------------------- alarm
   // Evaluated on the window's next-state values so it moves on the same edge as the count.
   // It can only be set while full, and only clear/reset empty the window, which also
   // drop the alarm, so it is never seen asserted with a partial window.
   assign hits_cmp = {1'b0, win_hits_next};

   always_comb begin
      alarm_d = alarm_q;
      if (bus.clear) begin
         alarm_d = 1'b0;
      end else if (win_full_next && (hits_cmp < SetThr)) begin
         alarm_d = 1'b1;
      end else if (hits_cmp >= ClrThr) begin
         alarm_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         total_q   <= '0;
         correct_q <= '0;
         miss_q    <= '0;
         cur_q     <= '0;
         max_q     <= '0;
         alarm_q   <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         total_q   <= total_d;
         correct_q <= correct_d;
         miss_q    <= miss_d;
         cur_q     <= cur_d;
         max_q     <= max_d;
         alarm_q   <= alarm_d;
         sat_q     <= sat_d;
      end
   end

   assign bus.total_count      = total_q;
   assign bus.correct_count    = correct_q;
   assign bus.mispredict_count = miss_q;
   assign bus.cur_miss_streak  = cur_q;
   assign bus.max_miss_streak  = max_q;
   assign bus.window_hits      = win_hits;
   assign bus.window_full      = win_full;
   assign bus.low_acc_alarm    = alarm_q;
   assign bus.sat_flag         = sat_q;
   assign bus.running          = running_q;

endmodule

// File: tb/tb_branch_accuracy_monitor.sv
// Self-checking bench for branch_accuracy_monitor: a vector table for the basic flow and
// control conflicts, plus hand sequences for window/alarm, streak saturation and reset.
module tb_branch_accuracy_monitor;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   branch_accuracy_monitor_if                  bus_a ();
   branch_accuracy_monitor_if #(.STREAK_W (3)) bus_b ();

   branch_accuracy_monitor dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   branch_accuracy_monitor #(
      .STREAK_W (3)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        st, sp, cl, v, p, o;
      logic [15:0] tot, cor, mis;
      logic [7:0]  cur, mx;
      logic [4:0]  wh;
      logic        wf, al, sf, run;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input logic st, sp, cl, v, p, o,
                                input int tot, cor, mis, cur, mx, wh,
                                input logic wf, al, sf, run);
      vec_t r;
      r.st = st; r.sp = sp; r.cl = cl; r.v = v; r.p = p; r.o = o;
      r.tot = 16'(tot); r.cor = 16'(cor); r.mis = 16'(mis);
      r.cur = 8'(cur); r.mx = 8'(mx); r.wh = 5'(wh);
      r.wf = wf; r.al = al; r.sf = sf; r.run = run;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic st, sp, cl, v, p, o);
      bus_a.start = st; bus_a.stop = sp; bus_a.clear = cl;
      bus_a.sample_valid = v; bus_a.prediction = p; bus_a.branch_outcome = o;
   endtask

   task automatic drive_b(input logic st, sp, cl, v, p, o);
      bus_b.start = st; bus_b.stop = sp; bus_b.clear = cl;
      bus_b.sample_valid = v; bus_b.prediction = p; bus_b.branch_outcome = o;
   endtask

   task automatic step_a(input logic st, sp, cl, v, p, o);
      drive_a(st, sp, cl, v, p, o);
      @(posedge clk);
      #1;
   endtask

   task automatic step_b(input logic st, sp, cl, v, p, o);
      drive_b(st, sp, cl, v, p, o);
      @(posedge clk);
      #1;
   endtask

   task automatic check_vec_a(input string tag, input vec_t e);
      chk({tag, ".total"},   32'(bus_a.total_count),      32'(e.tot));
      chk({tag, ".correct"}, 32'(bus_a.correct_count),    32'(e.cor));
      chk({tag, ".miss"},    32'(bus_a.mispredict_count), 32'(e.mis));
      chk({tag, ".cur"},     32'(bus_a.cur_miss_streak),  32'(e.cur));
      chk({tag, ".max"},     32'(bus_a.max_miss_streak),  32'(e.mx));
      chk({tag, ".whits"},   32'(bus_a.window_hits),      32'(e.wh));
      chk({tag, ".wfull"},   32'(bus_a.window_full),      32'(e.wf));
      chk({tag, ".alarm"},   32'(bus_a.low_acc_alarm),    32'(e.al));
      chk({tag, ".sat"},     32'(bus_a.sat_flag),         32'(e.sf));
      chk({tag, ".running"}, 32'(bus_a.running),          32'(e.run));
   endtask

   initial begin
      // ------------------------------------------------------------ vector table
      vecs.push_back(mkv(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // start+stop in IDLE
      for (int i = 0; i < 5; i++)                                            // samples in IDLE
         vecs.push_back(mkv(0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mkv(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1)); // start
      for (int k = 1; k <= 10; k++)                                          // 10 hits
         vecs.push_back(mkv(0, 0, 0, 1, k[0], k[0],  k, k, 0, 0, 0, k,  0, 0, 0, 1));
      vecs.push_back(mkv(0, 1, 0, 1, 1, 0,  11, 10, 1, 1, 1, 10,  0, 0, 0, 0)); // stop+miss
      vecs.push_back(mkv(0, 0, 0, 1, 0, 1,  11, 10, 1, 1, 1, 10,  0, 0, 0, 0)); // HALT drop
      vecs.push_back(mkv(0, 0, 0, 1, 0, 1,  11, 10, 1, 1, 1, 10,  0, 0, 0, 0));
      vecs.push_back(mkv(1, 1, 0, 0, 0, 0,  11, 10, 1, 1, 1, 10,  0, 0, 0, 0)); // stop wins
      vecs.push_back(mkv(1, 0, 0, 0, 0, 0,  11, 10, 1, 1, 1, 10,  0, 0, 0, 1)); // resume
      vecs.push_back(mkv(0, 0, 0, 1, 0, 0,  12, 11, 1, 0, 1, 11,  0, 0, 0, 1)); // hit
      vecs.push_back(mkv(0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1));    // clear+sample
      vecs.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 1,  0, 0, 0, 1));
      vecs.push_back(mkv(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1));    // clear

      // ------------------------------------------------------------ reset
      reset = 1'b1;
      drive_a(0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_vec_a("reset", mkv(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      chk("reset_b.max", 32'(bus_b.max_miss_streak), 0);
      chk("reset_b.sat", 32'(bus_b.sat_flag), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step_a(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].v, vecs[i].p, vecs[i].o);
         check_vec_a($sformatf("v%0d", i), vecs[i]);
      end

      // ------------------------------------------------------------ 16 misses, 10 hits
      for (int i = 1; i <= 16; i++) begin
         step_a(0, 0, 0, 1, 1, 0);
         chk($sformatf("miss%0d.cur", i),   32'(bus_a.cur_miss_streak), 32'(i));
         chk($sformatf("miss%0d.wfull", i), 32'(bus_a.window_full),     32'(i == 16));
         chk($sformatf("miss%0d.alarm", i), 32'(bus_a.low_acc_alarm),   32'(i == 16));
      end
      chk("miss16.max",   32'(bus_a.max_miss_streak), 16);
      chk("miss16.whits", 32'(bus_a.window_hits), 0);
      for (int j = 1; j <= 10; j++) begin
         step_a(0, 0, 0, 1, 0, 0);
         chk($sformatf("rec%0d.whits", j), 32'(bus_a.window_hits),   32'(j));
         chk($sformatf("rec%0d.alarm", j), 32'(bus_a.low_acc_alarm), 32'(j < 10));
      end
      chk("rec10.cur", 32'(bus_a.cur_miss_streak), 0);
      chk("rec10.max", 32'(bus_a.max_miss_streak), 16);

      // ------------------------------------------------------------ alternating, hysteresis
      step_a(0, 0, 1, 0, 0, 0);
      for (int i = 1; i <= 32; i++) begin
         step_a(0, 0, 0, 1, 1, i[0]);
         chk($sformatf("alt%0d.whits", i), 32'(bus_a.window_hits),
             (i < 16) ? 32'((i + 1) / 2) : 32'd8);
         chk($sformatf("alt%0d.wfull", i), 32'(bus_a.window_full),   32'(i >= 16));
         chk($sformatf("alt%0d.alarm", i), 32'(bus_a.low_acc_alarm), 0);
      end
      step_a(0, 0, 0, 1, 1, 0);
      chk("hyst_miss.whits", 32'(bus_a.window_hits), 7);
      chk("hyst_miss.alarm", 32'(bus_a.low_acc_alarm), 1);
      step_a(0, 0, 0, 1, 1, 1);
      chk("hyst_hit.whits", 32'(bus_a.window_hits), 8);
      chk("hyst_hit.alarm", 32'(bus_a.low_acc_alarm), 1);

      // ------------------------------------------------------------ streak saturation (3 bit)
      step_b(1, 0, 0, 0, 0, 0);
      chk("b_start.running", 32'(bus_b.running), 1);
      for (int i = 1; i <= 9; i++) begin
         step_b(0, 0, 0, 1, 0, 1);
         chk($sformatf("bsat%0d.cur", i), 32'(bus_b.cur_miss_streak), (i < 7) ? 32'(i) : 32'd7);
         chk($sformatf("bsat%0d.sat", i), 32'(bus_b.sat_flag),        32'(i >= 8));
      end
      chk("bsat9.max", 32'(bus_b.max_miss_streak), 7);
      step_b(0, 0, 0, 1, 1, 1);
      chk("bhit.cur", 32'(bus_b.cur_miss_streak), 0);
      chk("bhit.max", 32'(bus_b.max_miss_streak), 7);
      chk("bhit.sat", 32'(bus_b.sat_flag), 1);
      step_b(0, 0, 1, 0, 0, 0);
      chk("bclr.sat",   32'(bus_b.sat_flag), 0);
      chk("bclr.max",   32'(bus_b.max_miss_streak), 0);
      chk("bclr.total", 32'(bus_b.total_count), 0);
      drive_b(0, 0, 0, 0, 0, 0);

      // ------------------------------------------------------------ reset mid-run
      step_a(0, 0, 1, 0, 0, 0);
      for (int i = 1; i <= 11; i++) step_a(0, 0, 0, 1, 1, 1);
      chk("prerst.total", 32'(bus_a.total_count), 11);
      reset = 1'b1;
      step_a(0, 0, 0, 1, 1, 1);
      reset = 1'b0;
      check_vec_a("midrst", mkv(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      step_a(0, 0, 0, 1, 1, 1);
      chk("postrst_idle.total", 32'(bus_a.total_count), 0);
      step_a(1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step_a(0, 0, 0, 1, 0, 0);
      check_vec_a("postrst", mkv(0, 0, 0, 0, 0, 0,  3, 3, 0, 0, 0, 3,  0, 0, 0, 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
